// File: rtl/addsub_acc_pipe_if.sv
// Operand/result bundle for addsub_acc_pipe: producer drives master, the pipe takes slave.
// Port names mirror the block's pin list so generated datapaths can wire them directly.
interface addsub_acc_pipe_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic [1:0]       OP;
  logic             CLR;
  logic             I_VALID;
  logic             I_READY;
  logic [WIDTH-1:0] O;
  logic             COUT;
  logic             OVF;
  logic             O_VALID;
  logic             O_READY;
  logic [WIDTH-1:0] ACC;

  modport master (
    output I0, I1, OP, CLR, I_VALID, O_READY,
    input  I_READY, O, COUT, OVF, O_VALID, ACC
  );

  modport slave (
    input  I0, I1, OP, CLR, I_VALID, O_READY,
    output I_READY, O, COUT, OVF, O_VALID, ACC
  );
endinterface

// File: rtl/addsub_acc_pipe.sv
// WIDTH-bit add/sub/accumulate, 2-cycle latency, 1/cycle; whole pipe stalls on !O_READY, I_READY
// drops only when both stages are full. `define ADDSUB_ACC_SAT_EN for signed saturation on overflow.
module addsub_acc_pipe #(
  parameter int WIDTH = 8
) (
  input logic              CLK,
  input logic              ASYNCRESET,
  addsub_acc_pipe_if.slave bus
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_i0_q, s1_i0_d;
  logic [WIDTH-1:0] s1_i1_q, s1_i1_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic             s1_clr_q, s1_clr_d;
  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             adv, i_ready, accept, sub, ovf;
  logic [WIDTH-1:0] a_sel, x, y, y_eff, res;
  logic [WIDTH:0]   sum;

  always_comb begin
    adv     = !o_valid_q || bus.O_READY;
    i_ready = adv || !s1_valid_q;
    accept  = bus.I_VALID && i_ready;

    // ACC ops read the accumulator in stage 2, so consecutive ACC beats chain without a hazard.
    sub   = s1_op_q[0];
    a_sel = s1_clr_q ? '0 : acc_q;
    x     = s1_op_q[1] ? a_sel : s1_i0_q;
    y     = s1_op_q[1] ? s1_i0_q : s1_i1_q;
    y_eff = sub ? ~y : y;
    sum   = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
    ovf   = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    res   = sum[WIDTH-1:0];
`ifdef ADDSUB_ACC_SAT_EN
    if (ovf) begin
      res = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif

    s1_valid_d = accept || (s1_valid_q && !adv);
    s1_i0_d    = s1_i0_q;
    s1_i1_d    = s1_i1_q;
    s1_op_d    = s1_op_q;
    s1_clr_d   = s1_clr_q;
    if (accept) begin
      s1_i0_d  = bus.I0;
      s1_i1_d  = bus.I1;
      s1_op_d  = bus.OP;
      s1_clr_d = bus.CLR;
    end

    o_valid_d = o_valid_q;
    o_d       = o_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    acc_d     = acc_q;
    if (adv) begin
      o_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        o_d    = res;
        cout_d = sum[WIDTH];
        ovf_d  = ovf;
        if (s1_op_q[1]) begin
          acc_d = res;
        end else if (s1_clr_q) begin
          acc_d = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      s1_valid_q <= 1'b0;
      s1_i0_q    <= '0;
      s1_i1_q    <= '0;
      s1_op_q    <= 2'b00;
      s1_clr_q   <= 1'b0;
      o_valid_q  <= 1'b0;
      o_q        <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_i0_q    <= s1_i0_d;
      s1_i1_q    <= s1_i1_d;
      s1_op_q    <= s1_op_d;
      s1_clr_q   <= s1_clr_d;
      o_valid_q  <= o_valid_d;
      o_q        <= o_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      acc_q      <= acc_d;
    end
  end

  assign bus.I_READY = i_ready;
  assign bus.O       = o_q;
  assign bus.COUT    = cout_q;
  assign bus.OVF     = ovf_q;
  assign bus.O_VALID = o_valid_q;
  assign bus.ACC     = acc_q;

endmodule

// File: doc/addsub_acc_pipe.md
Name: addsub_acc_pipe

Overview:
Parametrised successor to the fixed 8-bit combinational add/sub blocks: a WIDTH-bit add/subtract/accumulate unit with a 2-stage valid/ready pipeline, carry/overflow flags and an internal accumulator. It sits between operand producers and result consumers in generated datapaths. Subtraction is carried out as I0 + ~I1 + 1, using the carry-in.

Parameters:
WIDTH, 8, operand/result/accumulator width in bits (>=2)

Ports:
CLK  input  1  clock, rising edge
ASYNCRESET  input  1  asynchronous reset, active-high
I0  input  WIDTH  operand A (ACC ops: addend/subtrahend)
I1  input  WIDTH  operand B (ignored for ACC ops)
OP  input  2  00 ADD, 01 SUB, 10 ACC_ADD, 11 ACC_SUB
CLR  input  1  clear accumulator (qualified by handshake, see Behaviour)
I_VALID  input  1  input transaction valid
I_READY  output  1  input can be accepted
O  output  WIDTH  result
COUT  output  1  unsigned carry out (SUB: 1 = no borrow)
OVF  output  1  signed two's-complement overflow
O_VALID  output  1  result valid
O_READY  input  1  consumer accepts result
ACC  output  WIDTH  current accumulator value

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-high on ASYNCRESET. Assertion at any time, including mid-operation, immediately clears s1_valid, O_VALID, O, COUT, OVF and ACC to 0. All in-flight transactions are dropped.
- Stall control: adv = !O_VALID || O_READY. The whole pipe advances together; there is no partial advance.
- I_READY = adv || !s1_valid. Combinational, with no dependency on I_VALID. Reads 1 after reset.
- Accept: on I_VALID && I_READY, stage 1 registers I0, I1, OP and CLR, and s1_valid is set. An accepted beat remains captured after I_VALID falls.
- Stage 2: when adv, stage 2 loads the result of the stage-1 contents, and O_VALID <= s1_valid. If s1_valid is 0, O_VALID goes to 0.
- Latency: exactly 2 cycles from accept to O_VALID when unstalled. Throughput is 1 result per cycle.
- Arithmetic, computed at WIDTH+1 bits:
  - ADD: I0 + I1.
  - SUB: I0 + ~I1 + 1.
  - ACC_ADD: A + I0.
  - ACC_SUB: A + ~I0 + 1.
  - A is the accumulator value seen by the op: A = 0 if the beat's CLR = 1, else ACC.
- Result width rules:
  - O = low WIDTH bits of the sum.
  - COUT = bit WIDTH of the sum.
  - OVF = operand sign bits equal (after inversion for subtract) and result sign differs.
- Accumulator: ACC is read and written only in stage 2, so back-to-back ACC ops see the updated value with no hazard.
  - On an ACC op entering stage 2, ACC <= O.
  - On ADD/SUB with CLR = 1, ACC <= 0.
  - On ADD/SUB with CLR = 0, ACC is unchanged.
- Output hold: while O_VALID && !O_READY, O, COUT, OVF and O_VALID hold stable, and ACC does not change.
- Simultaneous events: accept and output drain in the same cycle are supported, with no bubble inserted.
- Wrap-around: modulo 2^WIDTH. WIDTH=8 example: 0xFF + 0x01 gives O = 0x00, COUT = 1.

Optional Feature:
Macro: ADDSUB_ACC_SAT_EN.
- Defined: signed saturation on all ops when OVF = 1. O becomes 0x7F..F if the true result is positive, 0x80..0 if negative. ACC ops store the saturated value into ACC. COUT still reflects the raw carry.
- Undefined: plain modulo wrap, no saturation logic instantiated.

Test Plan:
1. WIDTH=8, ADD I0=0x0F I1=0x01 accepted at cycle t -> O_VALID at t+2, O=0x10, COUT=0, OVF=0; then 0xFF+0x01 -> O=0x00, COUT=1, OVF=0.
2. SUB 0x05-0x07 -> O=0xFE, COUT=0, OVF=0; then SUB 0x80-0x01 -> O=0x7F, COUT=1, OVF=1 (with ADDSUB_ACC_SAT_EN: O=0x80).
3. ACC_ADD I0=0x10 with CLR=1, then two ACC_ADD 0x10 back-to-back, then ACC_SUB 0x40 -> O = 0x10, 0x20, 0x30, 0xF0 on consecutive cycles; ACC ends at 0xF0.
4. O_READY=0 for 5 cycles while 4 beats are offered -> I_READY drops after 2 are held; on release all 4 results emerge in order, with none lost or duplicated, and O stays stable while stalled.
5. ASYNCRESET pulsed mid-cycle with 2 beats in flight and ACC=0x30 -> O_VALID=0 and ACC=0 immediately (before the next edge); I_READY=1 after release; a fresh ADD completes with 2-cycle latency.
6. With ADDSUB_ACC_SAT_EN: ADD 0x7F+0x01 -> O=0x7F, OVF=1; repeated ACC_ADD 0x40 from 0 -> ACC 0x40, 0x7F, 0x7F.
